// File: rtl/aptpu_pkg.sv
// Shared definitions for the approximate-TPU datapath blocks.
//   APTPU_ADDER_LENGTH   : default operand width of the shared adders
//   APTPU_IMPRECISE_PART : default width of the approximate LSB field
//   APTPU_NUM_REQ        : default requester count for the arbiters
//   id_width()           : requester-ID width (at least one bit)
package aptpu_pkg;

    localparam int APTPU_ADDER_LENGTH   = 32;
    localparam int APTPU_IMPRECISE_PART = 16;
    localparam int APTPU_NUM_REQ        = 4;

    // A single requester would otherwise yield a zero-width ID bus.
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hoeraa_adder.sv
// Combinational approximate adder.
// The low IMPRECISE_PART bits are approximated; the bits above them form an
// exact ripple-carry add whose carry-in is generated from the top approximate
// bit pair.
// Ports:
//   a, b : operands, ADDER_LENGTH bits
//   sum  : approximate sum, ADDER_LENGTH+1 bits (MSB is carry-out)
module hoeraa_adder
    import aptpu_pkg::*;
#(
    parameter int ADDER_LENGTH   = APTPU_ADDER_LENGTH,
    parameter int IMPRECISE_PART = APTPU_IMPRECISE_PART
) (
    input  logic [ADDER_LENGTH-1:0] a,
    input  logic [ADDER_LENGTH-1:0] b,
    output logic [ADDER_LENGTH:0]   sum
);

    localparam int HI_W = ADDER_LENGTH - IMPRECISE_PART;

    logic            carry_in;
    logic [HI_W:0]   hi_sum;

    // Carry into the exact part comes only from the top approximate bit pair.
    assign carry_in = a[IMPRECISE_PART-1] & b[IMPRECISE_PART-1];

    // Bits below IP-2 are forced high; the field is empty when IP == 2.
    generate
        if (IMPRECISE_PART > 2) begin : g_fill
            assign sum[IMPRECISE_PART-3:0] = '1;
        end
    endgenerate

    assign sum[IMPRECISE_PART-2] = a[IMPRECISE_PART-2] | b[IMPRECISE_PART-2];

    // When the top pair generates a carry, the bit becomes the AND of the
    // pair below it instead of the OR of its own pair.
    assign sum[IMPRECISE_PART-1] = carry_in ? (a[IMPRECISE_PART-2] & b[IMPRECISE_PART-2])
                                            : (a[IMPRECISE_PART-1] | b[IMPRECISE_PART-1]);

    assign hi_sum = {1'b0, a[ADDER_LENGTH-1:IMPRECISE_PART]}
                  + {1'b0, b[ADDER_LENGTH-1:IMPRECISE_PART]}
                  + {{HI_W{1'b0}}, carry_in};

    assign sum[ADDER_LENGTH:IMPRECISE_PART] = hi_sum;

endmodule

// File: rtl/hoeraa_add_arbiter.sv
// Round-robin scheduler sharing one hoeraa_adder among NUM_REQ requesters.
// Stage 1 registers the granted operand pair; the adder sits between stage 1
// and stage 2; stage 2 holds the tagged result for the response channel.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_ready  : per-requester handshake (ready is one-hot or zero)
//   req_a, req_b         : flattened operands, requester i at [i*AL +: AL]
//   rsp_valid/rsp_ready  : response handshake with backpressure
//   rsp_sum, rsp_id      : approximate sum (with carry-out) and requester ID
//   busy                 : either pipeline stage holds valid data
module hoeraa_add_arbiter
    import aptpu_pkg::*;
#(
    parameter int  NUM_REQ        = APTPU_NUM_REQ,
    parameter int  ADDER_LENGTH   = APTPU_ADDER_LENGTH,
    parameter int  IMPRECISE_PART = APTPU_IMPRECISE_PART,
    localparam int ID_W           = id_width(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*ADDER_LENGTH-1:0] req_a,
    input  logic [NUM_REQ*ADDER_LENGTH-1:0] req_b,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [ADDER_LENGTH:0]           rsp_sum,
    output logic [ID_W-1:0]                 rsp_id,
    output logic                            busy
);

    localparam int IX_W = ID_W + 1;

    logic [ADDER_LENGTH-1:0] a_slice [NUM_REQ];
    logic [ADDER_LENGTH-1:0] b_slice [NUM_REQ];

    logic                    op_vld;
    logic [ADDER_LENGTH-1:0] op_a;
    logic [ADDER_LENGTH-1:0] op_b;
    logic [ID_W-1:0]         op_id;
    logic [ID_W-1:0]         rr_ptr;

    logic                    s1_free;
    logic                    s2_free;
    logic                    grant_found;
    logic [ID_W-1:0]         grant_idx;
    logic [ID_W-1:0]         ptr_next;
    logic                    handshake;
    logic [ADDER_LENGTH:0]   add_sum;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign a_slice[gi]   = req_a[gi*ADDER_LENGTH +: ADDER_LENGTH];
            assign b_slice[gi]   = req_b[gi*ADDER_LENGTH +: ADDER_LENGTH];
            // Reset gating keeps ready low while rst_n is held, even though
            // the empty stages would otherwise look free.
            assign req_ready[gi] = rst_n & s1_free & grant_found
                                 & (grant_idx == ID_W'(gi));
        end
    endgenerate

    assign s2_free = !rsp_valid | rsp_ready;
    assign s1_free = !op_vld | s2_free;
    assign busy    = op_vld | rsp_valid;

    // First asserted valid at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        logic [IX_W-1:0] probe;
        logic [ID_W-1:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        probe       = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            probe = {1'b0, rr_ptr} + IX_W'(k);
            if (probe >= IX_W'(NUM_REQ)) begin
                probe = probe - IX_W'(NUM_REQ);
            end
            cand = probe[ID_W-1:0];
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign handshake = |(req_valid & req_ready);
    assign ptr_next  = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    hoeraa_adder #(
        .ADDER_LENGTH   (ADDER_LENGTH),
        .IMPRECISE_PART (IMPRECISE_PART)
    ) u_add (
        .a   (op_a),
        .b   (op_b),
        .sum (add_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_vld    <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= '0;
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_id    <= '0;
        end else begin
            // Stage 2: load from stage 1 when it can move, else drain.
            if (op_vld && s2_free) begin
                rsp_valid <= 1'b1;
                rsp_sum   <= add_sum;
                rsp_id    <= op_id;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end

            // Stage 1: a same-cycle handshake refills it as it empties.
            if (handshake) begin
                op_vld <= 1'b1;
                op_a   <= a_slice[grant_idx];
                op_b   <= b_slice[grant_idx];
                op_id  <= grant_idx;
                rr_ptr <= ptr_next;
            end else if (op_vld && s2_free) begin
                op_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hoeraa_add_arbiter.sv
// Self-checking bench for hoeraa_add_arbiter (default parameters).
// Inputs are driven 1 time unit after the rising edge; handshakes and
// response transfers are sampled on the falling edge, which sees exactly the
// values the next rising edge will act on.
module tb_hoeraa_add_arbiter;

    localparam int NREQ = 4;
    localparam int AL   = 32;
    localparam int IP   = 16;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*AL-1:0]   req_a;
    logic [NREQ*AL-1:0]   req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [AL:0]          rsp_sum;
    logic [IDW-1:0]       rsp_id;
    logic                 busy;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    typedef struct {
        int          id;
        logic [AL:0] sum;
    } exp_t;

    exp_t            exp_q[$];
    exp_t            sb_e;
    int              hs_log[$];
    int              rsp_log[$];
    int              rsp_cyc[$];
    logic [NREQ-1:0] hs_now = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hoeraa_add_arbiter #(
        .NUM_REQ        (NREQ),
        .ADDER_LENGTH   (AL),
        .IMPRECISE_PART (IP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        tests_run++;
        if (obs !== want) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, want, cyc);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Reference model of the approximate addition, built from the arithmetic
    // description: constant low field, OR/AND top pair, exact upper add.
    function automatic logic [AL:0] model_sum(input logic [AL-1:0] a, input logic [AL-1:0] b);
        logic [AL:0] r;
        logic [AL:0] hi;
        logic        c;
        r = '0;
        for (int k = 0; k < IP - 2; k++) r[k] = 1'b1;
        r[IP-2] = a[IP-2] | b[IP-2];
        c       = a[IP-1] & b[IP-1];
        r[IP-1] = c ? (a[IP-2] & b[IP-2]) : (a[IP-1] | b[IP-1]);
        hi = (33'(a) >> IP) + (33'(b) >> IP) + 33'(c);
        return (hi << IP) | (r & 33'h0_0000_FFFF);
    endfunction

    // Monitor and scoreboard.
    always @(negedge clk) begin
        hs_now = '0;
        if (rst_n) begin
            check("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
            if (rsp_valid && rsp_ready) begin
                rsp_log.push_back(int'(rsp_id));
                rsp_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    sb_e = exp_q.pop_front();
                    check("sb_id", 64'(rsp_id), 64'(sb_e.id));
                    check("sb_sum", 64'(rsp_sum), 64'(sb_e.sum));
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    hs_now[i] = 1'b1;
                    hs_log.push_back(i);
                    exp_q.push_back('{id: i,
                                      sum: model_sum(req_a[i*AL +: AL], req_b[i*AL +: AL])});
                end
            end
        end
    end

    always @(negedge rst_n) exp_q.delete();

    // Advance one cycle; requesters that handshook present fresh data and
    // optionally withdraw their valid.
    task automatic tick(input bit drop);
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (hs_now[i]) begin
                req_a[i*AL +: AL] = $urandom;
                req_b[i*AL +: AL] = $urandom;
                if (drop) req_valid[i] = 1'b0;
            end
        end
    endtask

    // One isolated transaction with latency and value checks.
    task automatic send_one(input int id, input logic [AL-1:0] a, input logic [AL-1:0] b,
                            input logic [AL:0] want);
        req_a[id*AL +: AL] = a;
        req_b[id*AL +: AL] = b;
        req_valid          = '0;
        req_valid[id]      = 1'b1;
        @(negedge clk);
        check("one_ready", 64'(req_ready[id]), 64'd1);
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
        @(negedge clk);
        check("one_lat_s1_rsp_valid", 64'(rsp_valid), 64'd0);
        check("one_lat_busy", 64'(busy), 64'd1);
        @(negedge clk);
        check("one_rsp_valid", 64'(rsp_valid), 64'd1);
        check("one_rsp_sum", 64'(rsp_sum), 64'(want));
        check("one_rsp_id", 64'(rsp_id), 64'(id));
        tick(0);
        tick(0);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            tick(0);
            guard++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AL:0] held_sum;
        logic [IDW-1:0] held_id;
        bit held;

        req_valid = '1;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*AL +: AL] = $urandom;
            req_b[i*AL +: AL] = $urandom;
        end

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_sum", 64'(rsp_sum), 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Round robin, all valid, 8 cycles.
        for (int k = 0; k < 8; k++) tick(0);
        req_valid = '0;
        repeat (3) tick(0);
        check("rr_hs_count", 64'(hs_log.size()), 64'd8);
        for (int k = 0; k < 8 && k < hs_log.size(); k++)
            check("rr_grant", 64'(hs_log[k]), 64'(k % 4));
        check("rr_rsp_count", 64'(rsp_log.size()), 64'd8);
        for (int k = 0; k < 8 && k < rsp_log.size(); k++) begin
            check("rr_rsp_id", 64'(rsp_log[k]), 64'(k % 4));
            check("rr_rsp_cycle", 64'(rsp_cyc[k]), 64'(rsp_cyc[0] + k));
        end

        // Directed arithmetic with latency.
        send_one(2, 32'h0001_0000, 32'h0001_0000, 33'h0_0002_3FFF);
        send_one(2, 32'h0000_C000, 32'h0000_C000, 33'h0_0001_FFFF);
        send_one(0, 32'hFFFF_FFFF, 32'h0001_0000, 33'h1_0000_FFFF);

        // Fairness after idle: 1 alone, then 0 and 3 together.
        hs_log.delete();
        req_valid = 4'b0010;
        tick(1);
        req_valid = 4'b1001;
        tick(1);
        tick(1);
        check("fair_hs_count", 64'(hs_log.size()), 64'd3);
        if (hs_log.size() == 3) begin
            check("fair_first", 64'(hs_log[0]), 64'd1);
            check("fair_second", 64'(hs_log[1]), 64'd3);
            check("fair_third", 64'(hs_log[2]), 64'd0);
        end
        drain();

        // Backpressure: 5 cycles of rsp_ready low with everyone valid.
        hs_log.delete();
        rsp_ready = 1'b0;
        req_valid = '1;
        held      = 1'b0;
        held_sum  = '0;
        held_id   = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                if (held) begin
                    check("bp_sum_stable", 64'(rsp_sum), 64'(held_sum));
                    check("bp_id_stable", 64'(rsp_id), 64'(held_id));
                end
                held     = 1'b1;
                held_sum = rsp_sum;
                held_id  = rsp_id;
            end
            tick(0);
        end
        @(negedge clk);
        check("bp_hs_count", 64'(hs_log.size()), 64'd2);
        check("bp_req_ready", 64'(req_ready), 64'd0);
        check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        check("bp_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        repeat (3) tick(0);
        req_valid = '0;
        drain();

        // Reset with both stages full.
        rsp_ready = 1'b0;
        req_valid = '1;
        repeat (3) tick(0);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_req_ready", 64'(req_ready), 64'd0);
        req_valid = 4'b1010;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_grant", 64'(req_ready), 64'b0010);
        tick(1);
        req_valid = '0;
        drain();
        repeat (2) tick(0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
